// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR load sequencer: state encoding, word modes
// and default sizing.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2,
        CHECK   = 2'd3
    } fir_state_e;

    localparam logic MODE_COEF   = 1'b1;
    localparam logic MODE_SAMPLE = 1'b0;

    localparam int DEF_NUM_TAPS       = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/fir_strobe_sync.sv
// Brings the asynchronous host strobe and mode pin into the clk domain and
// produces a registered single-cycle pulse on each strobe rising edge.
module fir_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_mode,
    output logic rise,
    output logic mode_s
);

    logic       valid_s1_r;
    logic       valid_s2_r;
    logic       valid_s3_r;
    logic       mode_s1_r;
    logic       mode_s2_r;
    logic       rise_r;
    logic [1:0] hold_r;

    // Two-stage synchronisers, edge-history flop and registered rise pulse.
    // valid_s3_r is pinned high until the synchroniser has refilled after
    // reset, so a strobe already high at reset release never looks like a
    // fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_s1_r <= 1'b0;
            valid_s2_r <= 1'b0;
            valid_s3_r <= 1'b1;
            mode_s1_r  <= 1'b0;
            mode_s2_r  <= 1'b0;
            rise_r     <= 1'b0;
            hold_r     <= 2'b11;
        end else begin
            valid_s1_r <= in_valid;
            valid_s2_r <= valid_s1_r;
            valid_s3_r <= valid_s2_r | hold_r[1];
            mode_s1_r  <= in_mode;
            mode_s2_r  <= mode_s1_r;
            rise_r     <= valid_s2_r & ~valid_s3_r;
            hold_r     <= {hold_r[0], 1'b0};
        end
    end

    assign rise   = rise_r;
    assign mode_s = mode_s2_r;

endmodule

// File: rtl/fir_load_sequencer.sv
// Turns slow host strobes into single-cycle FIR transfers and enforces a
// complete coefficient load before samples pass. FIR_LOAD_CHECKSUM_EN adds an
// XOR checksum word after each coefficient set.
module fir_load_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int NUM_TAPS       = DEF_NUM_TAPS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SCNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_mode,
    output logic [DATA_W-1:0] fir_x,
    output logic              fir_tvalid,
    output logic              fir_set_coeffs,
    output logic              coeffs_loaded,
    output logic              busy,
    output logic              err,
    output logic [SCNT_W-1:0] sample_cnt
);

    localparam int TAP_W = $clog2(NUM_TAPS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic              rise_s;
    logic              mode_s;
    logic [TAP_W-1:0]  tap_next_s;
    logic              load_done_s;
    logic              timeout_s;

    fir_state_e        state_r;
    logic [TAP_W-1:0]  tap_cnt_r;
    logic [TO_W-1:0]   timeout_cnt_r;
    logic [DATA_W-1:0] fir_x_r;
    logic              fir_tvalid_r;
    logic              fir_set_coeffs_r;
    logic              coeffs_loaded_r;
    logic              busy_r;
    logic              err_r;
    logic [SCNT_W-1:0] sample_cnt_r;

`ifdef FIR_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] xor_r;
    logic [DATA_W-1:0] xor_next_s;
`endif

    fir_strobe_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_mode  (in_mode),
        .rise     (rise_s),
        .mode_s   (mode_s)
    );

    // A coefficient arriving outside LOADING always starts a fresh set.
    always_comb begin
        if (state_r == LOADING) begin
            tap_next_s = tap_cnt_r + TAP_W'(1);
        end else begin
            tap_next_s = TAP_W'(1);
        end
        load_done_s = (tap_next_s == TAP_W'(NUM_TAPS));
        timeout_s   = (timeout_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`ifdef FIR_LOAD_CHECKSUM_EN
        if (state_r == LOADING) begin
            xor_next_s = xor_r ^ in_data;
        end else begin
            xor_next_s = in_data;
        end
`endif
    end

    // Idle-gap watchdog: only runs while a load (or checksum) is pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_cnt_r <= TO_W'(0);
        end else if (rise_s || !busy_r) begin
            timeout_cnt_r <= TO_W'(0);
        end else begin
            timeout_cnt_r <= timeout_cnt_r + TO_W'(1);
        end
    end

    // Load/sample sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= EMPTY;
            tap_cnt_r        <= TAP_W'(0);
            fir_x_r          <= DATA_W'(0);
            fir_tvalid_r     <= 1'b0;
            fir_set_coeffs_r <= 1'b0;
            coeffs_loaded_r  <= 1'b0;
            busy_r           <= 1'b0;
            err_r            <= 1'b0;
            sample_cnt_r     <= SCNT_W'(0);
`ifdef FIR_LOAD_CHECKSUM_EN
            xor_r            <= DATA_W'(0);
`endif
        end else begin
            fir_tvalid_r     <= 1'b0;
            fir_set_coeffs_r <= 1'b0;
            case (state_r)
                EMPTY, LOADING, READY: begin
                    if (rise_s) begin
                        case (mode_s)
                            MODE_COEF: begin
                                fir_x_r          <= in_data;
                                fir_tvalid_r     <= 1'b1;
                                fir_set_coeffs_r <= 1'b1;
                                tap_cnt_r        <= tap_next_s;
                                sample_cnt_r     <= SCNT_W'(0);
`ifdef FIR_LOAD_CHECKSUM_EN
                                xor_r            <= xor_next_s;
`endif
                                if (load_done_s) begin
`ifdef FIR_LOAD_CHECKSUM_EN
                                    state_r         <= CHECK;
                                    busy_r          <= 1'b1;
                                    coeffs_loaded_r <= 1'b0;
`else
                                    state_r         <= READY;
                                    busy_r          <= 1'b0;
                                    coeffs_loaded_r <= 1'b1;
                                    err_r           <= 1'b0;
`endif
                                end else begin
                                    state_r         <= LOADING;
                                    busy_r          <= 1'b1;
                                    coeffs_loaded_r <= 1'b0;
                                end
                            end
                            MODE_SAMPLE: begin
                                if (state_r == READY) begin
                                    fir_x_r      <= in_data;
                                    fir_tvalid_r <= 1'b1;
                                    sample_cnt_r <= sample_cnt_r + SCNT_W'(1);
                                end else begin
                                    err_r     <= 1'b1;
                                    state_r   <= EMPTY;
                                    busy_r    <= 1'b0;
                                    tap_cnt_r <= TAP_W'(0);
                                end
                            end
                            default: begin
                                state_r <= state_r;
                            end
                        endcase
                    end else if ((state_r == LOADING) && timeout_s) begin
                        err_r     <= 1'b1;
                        state_r   <= EMPTY;
                        busy_r    <= 1'b0;
                        tap_cnt_r <= TAP_W'(0);
                    end else begin
                        state_r <= state_r;
                    end
                end
`ifdef FIR_LOAD_CHECKSUM_EN
                // The checksum word is consumed here and never reaches the FIR.
                CHECK: begin
                    if (rise_s) begin
                        tap_cnt_r <= TAP_W'(0);
                        busy_r    <= 1'b0;
                        if (in_data == xor_r) begin
                            state_r         <= READY;
                            coeffs_loaded_r <= 1'b1;
                            err_r           <= 1'b0;
                        end else begin
                            state_r <= EMPTY;
                            err_r   <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        err_r     <= 1'b1;
                        state_r   <= EMPTY;
                        busy_r    <= 1'b0;
                        tap_cnt_r <= TAP_W'(0);
                    end else begin
                        state_r <= state_r;
                    end
                end
`endif
                default: begin
                    state_r         <= EMPTY;
                    busy_r          <= 1'b0;
                    coeffs_loaded_r <= 1'b0;
                    tap_cnt_r       <= TAP_W'(0);
                end
            endcase
        end
    end

    assign fir_x          = fir_x_r;
    assign fir_tvalid     = fir_tvalid_r;
    assign fir_set_coeffs = fir_set_coeffs_r;
    assign coeffs_loaded  = coeffs_loaded_r;
    assign busy           = busy_r;
    assign err            = err_r;
    assign sample_cnt     = sample_cnt_r;

endmodule
